// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the multi-channel ADC capture path.
// Holds the FSM state enum, default widths and the address-width helper.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP,
        WRITE
    } state_t;

    localparam int DEF_DATA_WIDTH    = 12;
    localparam int DEF_CHANNEL_WIDTH = 5;

    // Bits needed to index n items, never less than one.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_channel_sequencer.sv
// Round-robin scan-list walker: latches the channel list on load and
// steps one slot per advance.
// Ports: CLOCK, RESET (sync, active-high), load, advance, channel_list in;
//        channel (registered slot entry), last_slot out.
module adc_channel_sequencer
    import adc_capture_pkg::*;
#(
    parameter int CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
    parameter int NUM_CHANNELS  = 4
) (
    input  logic                                  CLOCK,
    input  logic                                  RESET,
    input  logic                                  load,
    input  logic                                  advance,
    input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] channel_list,
    output logic [CHANNEL_WIDTH-1:0]              channel,
    output logic                                  last_slot
);

    localparam int SW = addr_width(NUM_CHANNELS);

    logic [SW-1:0]            slot;
    logic [SW-1:0]            next_slot;
    logic [CHANNEL_WIDTH-1:0] list_q [NUM_CHANNELS];

    assign last_slot = (slot == SW'(NUM_CHANNELS - 1));
    assign next_slot = last_slot ? '0 : slot + SW'(1);

    // channel is loaded with the entry of the slot being entered, so it is
    // already correct on the first cycle of the following ISSUE.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            slot    <= '0;
            channel <= '0;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                list_q[k] <= '0;
            end
        end else if (load) begin
            slot    <= '0;
            channel <= channel_list[0 +: CHANNEL_WIDTH];
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                list_q[k] <= channel_list[k*CHANNEL_WIDTH +: CHANNEL_WIDTH];
            end
        end else if (advance) begin
            slot    <= next_slot;
            channel <= list_q[next_slot];
        end
    end

endmodule

// File: rtl/adc_multichannel_capture.sv
// Sequences ADC conversions over a scan list and writes them, interleaved
// by channel, into a single-port RAM as fixed-length frames.
// Ports: CLOCK, RESET, start, continuous, channel_list in; command_* to the
//        ADC core, response_* from it; ram_we/ram_addr/ram_wdata to the RAM;
//        busy, frame_done, overrun status. All outputs registered.
module adc_multichannel_capture
    import adc_capture_pkg::*;
#(
    parameter int  DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int  CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
    parameter int  NUM_CHANNELS  = 4,
    parameter int  DEPTH         = 256,
    localparam int ADDR_WIDTH    = addr_width(DEPTH * NUM_CHANNELS)
) (
    input  logic                                  CLOCK,
    input  logic                                  RESET,
    input  logic                                  start,
    input  logic                                  continuous,
    input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] channel_list,
    output logic                                  command_valid,
    output logic [CHANNEL_WIDTH-1:0]              command_channel,
    input  logic                                  command_ready,
    input  logic                                  response_valid,
    input  logic [DATA_WIDTH-1:0]                 response_data,
    output logic                                  ram_we,
    output logic [ADDR_WIDTH-1:0]                 ram_addr,
    output logic [DATA_WIDTH-1:0]                 ram_wdata,
    output logic                                  busy,
    output logic                                  frame_done,
    output logic                                  overrun
);

    localparam int SMW = addr_width(DEPTH);

    state_t         state;
    state_t         next_state;
    logic           cont_q;
    logic [SMW-1:0] sample_cnt;
    logic           last_slot;
    logic           last_sample;
    logic           last_word;
    logic           accept_start;
    logic           unexpected;

    assign accept_start = (state == IDLE) && start;
    assign unexpected   = response_valid && (state != WAIT_RESP);
    assign last_sample  = (sample_cnt == SMW'(DEPTH - 1));
    assign last_word    = last_slot && last_sample;

    adc_channel_sequencer #(
        .CHANNEL_WIDTH (CHANNEL_WIDTH),
        .NUM_CHANNELS  (NUM_CHANNELS)
    ) u_seq (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .load         (accept_start),
        .advance      (state == WRITE),
        .channel_list (channel_list),
        .channel      (command_channel),
        .last_slot    (last_slot)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (start) next_state = ISSUE;
            ISSUE:     if (command_ready) next_state = WAIT_RESP;
            WAIT_RESP: if (response_valid) next_state = WRITE;
            WRITE: begin
                if (last_word && !cont_q) next_state = IDLE;
                else                      next_state = ISSUE;
            end
        endcase
    end

    // Outputs are registered from next_state so they line up with the
    // state they describe rather than trailing it by a cycle.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            command_valid <= 1'b0;
            ram_we        <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            overrun       <= 1'b0;
            cont_q        <= 1'b0;
            sample_cnt    <= '0;
        end else begin
            command_valid <= (next_state == ISSUE);
            busy          <= (next_state != IDLE);
            ram_we        <= (next_state == WRITE);
            frame_done    <= (next_state == WRITE) && last_word;
            overrun       <= (overrun && !accept_start) || unexpected;

            if (accept_start) begin
                cont_q     <= continuous;
                sample_cnt <= '0;
                ram_addr   <= '0;
            end

            if (state == WAIT_RESP && response_valid) begin
                ram_wdata <= response_data;
            end

            if (state == WRITE) begin
                if (last_word) begin
                    sample_cnt <= '0;
                    ram_addr   <= '0;
                end else begin
                    ram_addr <= ram_addr + ADDR_WIDTH'(1);
                    if (last_slot) sample_cnt <= sample_cnt + SMW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_multichannel_capture.sv
// Scoreboard bench for adc_multichannel_capture: a 4x2 single-shot
// instance and a 2x1 continuous instance, each with an ADC stand-in.
module tb_adc_multichannel_capture;

    typedef struct {
        int addr;
        int data;
        int fd;
    } wr_t;

    logic        CLOCK;
    logic        RESET;

    logic        start_a, continuous_a;
    logic [19:0] channel_list_a;
    logic        command_valid_a, command_ready_a;
    logic [4:0]  command_channel_a;
    logic        response_valid_a;
    logic [11:0] response_data_a;
    logic        ram_we_a, busy_a, frame_done_a, overrun_a;
    logic [2:0]  ram_addr_a;
    logic [11:0] ram_wdata_a;

    logic        start_b, continuous_b;
    logic [9:0]  channel_list_b;
    logic        command_valid_b, command_ready_b;
    logic [4:0]  command_channel_b;
    logic        response_valid_b;
    logic [11:0] response_data_b;
    logic        ram_we_b, busy_b, frame_done_b, overrun_b;
    logic [0:0]  ram_addr_b;
    logic [11:0] ram_wdata_b;

    adc_multichannel_capture #(
        .DATA_WIDTH(12), .CHANNEL_WIDTH(5), .NUM_CHANNELS(4), .DEPTH(2)
    ) dut_a (
        .CLOCK(CLOCK), .RESET(RESET), .start(start_a),
        .continuous(continuous_a), .channel_list(channel_list_a),
        .command_valid(command_valid_a), .command_channel(command_channel_a),
        .command_ready(command_ready_a), .response_valid(response_valid_a),
        .response_data(response_data_a), .ram_we(ram_we_a),
        .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .busy(busy_a),
        .frame_done(frame_done_a), .overrun(overrun_a)
    );

    adc_multichannel_capture #(
        .DATA_WIDTH(12), .CHANNEL_WIDTH(5), .NUM_CHANNELS(2), .DEPTH(1)
    ) dut_b (
        .CLOCK(CLOCK), .RESET(RESET), .start(start_b),
        .continuous(continuous_b), .channel_list(channel_list_b),
        .command_valid(command_valid_b), .command_channel(command_channel_b),
        .command_ready(command_ready_b), .response_valid(response_valid_b),
        .response_data(response_data_b), .ram_we(ram_we_b),
        .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .busy(busy_b),
        .frame_done(frame_done_b), .overrun(overrun_b)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    wr_t exp_wr_a[$];
    int  exp_cmd_a[$];
    wr_t exp_wr_b[$];
    int  fd_cnt_b = 0;
    int  last_fd_b = 0;

    // ADC stand-ins: answer one cycle after each accepted command.
    logic        hs_a, hs_b, auto_a;
    logic        auto_v_a, man_v_a, auto_v_b;
    logic [11:0] auto_d_a, man_d_a, auto_d_b;
    int          n_a = 0;
    int          n_b = 0;

    assign response_valid_a = auto_a ? auto_v_a : man_v_a;
    assign response_data_a  = auto_a ? auto_d_a : man_d_a;
    assign response_valid_b = auto_v_b;
    assign response_data_b  = auto_d_b;

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    always @(posedge CLOCK) cyc++;

    always @(negedge CLOCK) begin
        hs_a = command_valid_a && command_ready_a;
        hs_b = command_valid_b && command_ready_b;
    end

    initial begin
        auto_v_a = 1'b0; auto_d_a = '0;
        forever begin
            @(posedge CLOCK); #1;
            auto_v_a = hs_a;
            if (hs_a) begin
                auto_d_a = 12'(100 + n_a);
                n_a++;
            end
        end
    end

    initial begin
        auto_v_b = 1'b0; auto_d_b = '0;
        forever begin
            @(posedge CLOCK); #1;
            auto_v_b = hs_b;
            if (hs_b) begin
                auto_d_b = 12'(200 + n_b);
                n_b++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge CLOCK) begin : mon_a
        wr_t w;
        if (ram_we_a) begin
            check("wr_a_expected", int'(exp_wr_a.size() > 0), 1);
            if (exp_wr_a.size() > 0) begin
                w = exp_wr_a.pop_front();
                check("wr_a_addr", int'(ram_addr_a), w.addr);
                check("wr_a_data", int'(ram_wdata_a), w.data);
                check("wr_a_frame_done", int'(frame_done_a), w.fd);
            end
        end
        if (frame_done_a) check("fd_a_with_we", int'(ram_we_a), 1);
        if (command_valid_a && command_ready_a) begin
            check("cmd_a_expected", int'(exp_cmd_a.size() > 0), 1);
            if (exp_cmd_a.size() > 0)
                check("cmd_a_channel", int'(command_channel_a),
                      exp_cmd_a.pop_front());
        end
    end

    always @(negedge CLOCK) begin : mon_b
        wr_t w;
        if (ram_we_b) begin
            check("wr_b_expected", int'(exp_wr_b.size() > 0), 1);
            if (exp_wr_b.size() > 0) begin
                w = exp_wr_b.pop_front();
                check("wr_b_addr", int'(ram_addr_b), w.addr);
                check("wr_b_data", int'(ram_wdata_b), w.data);
                check("wr_b_frame_done", int'(frame_done_b), w.fd);
            end
        end
        if (frame_done_b) begin
            if (fd_cnt_b > 0) check("fd_b_gap", cyc - last_fd_b, 6);
            last_fd_b = cyc;
            fd_cnt_b++;
        end
    end

    // Scan list {3,7,1,0}: slot 0 holds 0, so commands run 0,1,7,3.
    task automatic push_frame_a(input int base);
        int chans[4];
        wr_t w;
        chans = '{0, 1, 7, 3};
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 4; k++) begin
                exp_cmd_a.push_back(chans[k]);
                w.addr = s * 4 + k;
                w.data = 100 + base + s * 4 + k;
                w.fd   = (s == 1 && k == 3) ? 1 : 0;
                exp_wr_a.push_back(w);
            end
        end
    endtask

    task automatic pulse_start_a();
        @(posedge CLOCK); #1 start_a = 1'b1;
        @(posedge CLOCK); #1 start_a = 1'b0;
        @(negedge CLOCK);
        check("start_to_cmd", int'(command_valid_a), 1);
    endtask

    task automatic wait_fd_a();
        int got = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLOCK);
            if (frame_done_a) begin
                got = 1;
                break;
            end
        end
        check("fd_a_seen", got, 1);
        @(negedge CLOCK);
        check("busy_after_fd", int'(busy_a), 0);
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_cmd_valid"}, int'(command_valid_a), 0);
        check({tag, "_cmd_channel"}, int'(command_channel_a), 0);
        check({tag, "_ram_we"}, int'(ram_we_a), 0);
        check({tag, "_ram_addr"}, int'(ram_addr_a), 0);
        check({tag, "_ram_wdata"}, int'(ram_wdata_a), 0);
        check({tag, "_busy"}, int'(busy_a), 0);
        check({tag, "_frame_done"}, int'(frame_done_a), 0);
        check({tag, "_overrun"}, int'(overrun_a), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end

    initial begin
        wr_t w;
        int got;
        RESET = 1'b1;
        start_a = 1'b0; continuous_a = 1'b0;
        channel_list_a = {5'd3, 5'd7, 5'd1, 5'd0};
        command_ready_a = 1'b1;
        auto_a = 1'b1; man_v_a = 1'b0; man_d_a = '0;
        start_b = 1'b0; continuous_b = 1'b0;
        channel_list_b = {5'd9, 5'd4};
        command_ready_b = 1'b1;

        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        check_zero_a("reset");
        check("reset_busy_b", int'(busy_b), 0);
        @(posedge CLOCK); #1 RESET = 1'b0;

        // Single-shot frame, immediate handshakes.
        push_frame_a(n_a);
        pulse_start_a();
        wait_fd_a();

        // Command stalled for 5 cycles.
        command_ready_a = 1'b0;
        push_frame_a(n_a);
        pulse_start_a();
        for (int k = 0; k < 5; k++) begin
            @(negedge CLOCK);
            check("stall_cmd_valid", int'(command_valid_a), 1);
            check("stall_cmd_channel", int'(command_channel_a), 0);
            check("stall_ram_we", int'(ram_we_a), 0);
        end
        @(posedge CLOCK); #1 command_ready_a = 1'b1;
        wait_fd_a();

        // Stray response while idle.
        auto_a = 1'b0;
        @(posedge CLOCK); #1 man_v_a = 1'b1; man_d_a = 12'hABC;
        @(posedge CLOCK); #1 man_v_a = 1'b0;
        @(negedge CLOCK);
        check("idle_resp_overrun", int'(overrun_a), 1);
        check("idle_resp_no_we", int'(ram_we_a), 0);
        auto_a = 1'b1;
        push_frame_a(n_a);
        pulse_start_a();
        check("start_clears_overrun", int'(overrun_a), 0);
        wait_fd_a();

        // Reset while waiting for a response.
        exp_cmd_a.push_back(0);
        auto_a = 1'b0;
        @(posedge CLOCK); #1 start_a = 1'b1;
        @(posedge CLOCK); #1 start_a = 1'b0;
        @(posedge CLOCK); #1 RESET = 1'b1;
        @(negedge CLOCK);
        check("wait_resp_busy", int'(busy_a), 1);
        @(posedge CLOCK); #1 RESET = 1'b0;
        @(negedge CLOCK);
        check_zero_a("midreset");
        @(posedge CLOCK); #1 man_v_a = 1'b1; man_d_a = 12'h555;
        @(posedge CLOCK); #1 man_v_a = 1'b0;
        @(negedge CLOCK);
        check("late_resp_no_we", int'(ram_we_a), 0);
        check("late_resp_overrun", int'(overrun_a), 1);
        auto_a = 1'b1;

        // Start and scan-list change mid-frame are ignored.
        push_frame_a(n_a);
        pulse_start_a();
        repeat (4) @(posedge CLOCK);
        #1 start_a = 1'b1; channel_list_a = {5'd31, 5'd30, 5'd29, 5'd28};
        @(posedge CLOCK); #1 start_a = 1'b0;
        wait_fd_a();
        for (int k = 0; k < 6; k++) begin
            @(negedge CLOCK);
            check("no_restart", int'(command_valid_a), 0);
        end
        check("wr_a_left", exp_wr_a.size(), 0);
        check("cmd_a_left", exp_cmd_a.size(), 0);

        // Continuous, 2 channels x 1 sample, three frames.
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 2; k++) begin
                w.addr = k;
                w.data = 200 + n_b + f * 2 + k;
                w.fd   = k;
                exp_wr_b.push_back(w);
            end
        end
        continuous_b = 1'b1;
        @(posedge CLOCK); #1 start_b = 1'b1;
        @(posedge CLOCK); #1 start_b = 1'b0; continuous_b = 1'b0;
        got = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLOCK);
            if (fd_cnt_b == 3) begin
                got = 1;
                break;
            end
        end
        check("fd_b_three_frames", got, 1);
        @(posedge CLOCK); #1 RESET = 1'b1;
        @(posedge CLOCK); #1 RESET = 1'b0;
        repeat (4) @(negedge CLOCK);
        check("wr_b_left", exp_wr_b.size(), 0);
        check("fd_b_count", fd_cnt_b, 3);
        check("busy_b_after_reset", int'(busy_b), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_multichannel_capture.md
# adc_multichannel_capture

Parametrised multi-channel successor to the single-channel ADC-into-RAM path. Sequences the ADC core's command interface round-robin over a programmable list of channels and writes each conversion into an external single-port RAM, channel-interleaved, as fixed-length frames. Supports single-shot and continuous capture, and flags responses that arrive when none is outstanding. Sits between the ADC core and the sample RAM in the top level, replacing direct per-channel wiring.

## Interface

- DATA_WIDTH, 12: ADC sample width.
- CHANNEL_WIDTH, 5: ADC channel-select width.
- NUM_CHANNELS, 4: slots in the scan list (≥1).
- DEPTH, 256: samples per channel per frame (≥1).
- ADDR_WIDTH, derived localparam = $clog2(DEPTH*NUM_CHANNELS), minimum 1.

Ports:

- CLOCK  in  1  sole clock.
- RESET  in  1  synchronous, active-high.
- start  in  1  one-cycle request to begin a frame.
- continuous  in  1  sampled at frame start; 1 = re-arm automatically after each frame.
- channel_list  in  NUM_CHANNELS*CHANNEL_WIDTH  slot k occupies bits [k*CHANNEL_WIDTH +: CHANNEL_WIDTH]; sampled at frame start.
- command_valid  out  1  command request to the ADC core.
- command_channel  out  CHANNEL_WIDTH  channel for the current command.
- command_ready  in  1  ADC core accepts the command.
- response_valid  in  1  conversion result valid.
- response_data  in  DATA_WIDTH  conversion result.
- ram_we  out  1  RAM write strobe.
- ram_addr  out  ADDR_WIDTH  RAM write address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when the last word of a frame is written.
- overrun  out  1  sticky; set by an unexpected response, cleared only by RESET or an accepted start.

## Operation

- States: IDLE, ISSUE, WAIT_RESP, WRITE.
- IDLE: on start, latch channel_list and continuous, clear slot, sample and address counters, clear overrun, go to ISSUE.
- ISSUE: command_valid=1, command_channel=latched slot entry. On command_valid & command_ready, go to WAIT_RESP.
- WAIT_RESP: on response_valid, register response_data into ram_wdata and go to WRITE.
- WRITE: assert ram_we for one cycle at ram_addr, then advance the counters:
  - ram_addr increments linearly, so word = sample*NUM_CHANNELS + slot.
  - slot wraps at NUM_CHANNELS-1, then sample increments.
  - If this write is the last slot of the last sample: pulse frame_done, reset the counters, and go to ISSUE if the latched continuous is 1, otherwise IDLE.
  - Otherwise go to ISSUE.
- One command is outstanding at most.
- A response_valid in IDLE, ISSUE or WRITE is discarded and sets overrun.
- start while busy is ignored. In continuous mode, dropping start or continuous has no effect until RESET.
- channel_list changes mid-frame are ignored.

## Timing

- Reset values: command_valid=0, command_channel=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=0, frame_done=0, overrun=0, state=IDLE.
- start to command_valid: 1 cycle.
- response_valid to ram_we: 1 cycle. ram_addr and ram_wdata are stable while ram_we is high.
- Minimum per-sample period: 3 cycles (ISSUE, WAIT_RESP, WRITE) when command_ready and response_valid are immediate.
- frame_done coincides with the final ram_we.
- Continuous mode: the next ISSUE follows frame_done with no idle gap, and ram_addr restarts at 0.
- RESET mid-frame: the next cycle returns every output to its reset value. No partial write completes, and a late response after reset is treated as unexpected (sets overrun only if not in WAIT_RESP).
- All outputs are registered.

## Structure

- Package adc_capture_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_RESP, WRITE);
  - the default values of DATA_WIDTH and CHANNEL_WIDTH;
  - the ADDR_WIDTH helper function.
- Sub-module adc_channel_sequencer holds the slot counter and the latched channel_list mux. Inputs: CLOCK, RESET, load, advance. Outputs: channel and last_slot.
- The top FSM owns the sample counter, address counter, RAM port and flags.

## Test plan

- Single-shot with NUM_CHANNELS=4, DEPTH=2, channel_list={3,7,1,0}, immediate ready and response, response_data = 100+n -> commands carry channels 0,1,7,3,0,1,7,3; ram_addr 0..7 receive 100..107; frame_done with the address-7 write; busy falls the next cycle.
- command_ready held low for 5 cycles -> command_valid and command_channel stay stable; no ram_we until the handshake completes.
- Continuous with DEPTH=1, NUM_CHANNELS=2 over 3 frames -> three frame_done pulses 6 cycles apart; ram_addr sequence 0,1,0,1,0,1.
- response_valid asserted in IDLE -> no ram_we and overrun=1; the next accepted start clears it.
- RESET asserted while in WAIT_RESP -> all outputs zero on the next cycle; a response arriving 2 cycles later produces no write.
- start pulsed mid-frame -> ignored; the frame completes with the correct 8 writes and no restart.
